breath_sequencer: RTL and testbench

Controller that drives the `period`/`pulse` inputs of the team's PWM generator to produce a breathing LED: ramps the compare value up, dwells, ramps down, dwells, repeats. Sits between top-level control (enable/one-shot) and the PWM generator instance. All updates are paced by an internal update tick; the generator's own buffering applies each new `pulse` at its next period boundary.

---
 rtl/breath_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_breath_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/breath_sequencer.sv
// Breathing-LED sequencer: ramps the PWM compare value up and down, paced by an update tick.
// Optional dwell at top/bottom of each breath is enabled by defining BREATH_HOLD_EN.
module breath_sequencer #(
  parameter int unsigned PERIOD       = 1000,
  parameter int unsigned UPDATE_CLKS  = 50_000,
  parameter int unsigned STEP         = 10,
  parameter int unsigned HOLD_UPDATES = 20
) (
  input  logic        sclk,
  input  logic        rst,
  input  logic        en,
  input  logic        once,
  output logic [25:0] period,
  output logic [25:0] pulse,
  output logic        busy,
  output logic        cycle_done
);

  localparam int unsigned PW = 26;
  localparam int unsigned AW = 27;
  localparam int unsigned TW = (UPDATE_CLKS > 1) ? $clog2(UPDATE_CLKS) : 1;

  localparam logic [AW-1:0] PERIOD_A  = AW'(PERIOD);
  localparam logic [AW-1:0] STEP_A    = AW'(STEP);
  localparam logic [PW-1:0] STEP_P    = PW'(STEP);
  localparam logic [PW-1:0] PULSE_MIN = PW'(1);
  localparam logic [PW-1:0] PULSE_MAX = PW'(PERIOD);
  localparam logic [TW-1:0] TICK_LAST = TW'(UPDATE_CLKS - 1);

`ifdef BREATH_HOLD_EN
  localparam int unsigned   HW        = (HOLD_UPDATES > 1) ? $clog2(HOLD_UPDATES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_UPDATES - 1);
`endif

  // Elaboration-time guard against an illegal parameter set
  if (PERIOD < 2 || PERIOD > 50_000_000 || UPDATE_CLKS < 1 || STEP < 1 ||
      STEP >= PERIOD || HOLD_UPDATES < 1) begin : g_cfg_err
    $error("breath_sequencer: illegal parameter set");
  end

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RISE    = 3'd1,
    ST_HOLD_HI = 3'd2,
    ST_FALL    = 3'd3,
    ST_HOLD_LO = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] period_q, period_d;
  logic [PW-1:0] pulse_q, pulse_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          once_q, once_d;
  logic          lock_q, lock_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
`ifdef BREATH_HOLD_EN
  logic [HW-1:0] hcnt_q, hcnt_d;
`endif

  logic          tick_c;
  logic [AW-1:0] pulse_up_c;
  logic [PW-1:0] pulse_dn_c;
  logic          breath_end_c;

  assign tick_c     = (tcnt_q == TICK_LAST);
  assign pulse_up_c = {1'b0, pulse_q} + STEP_A;
  assign pulse_dn_c = pulse_q - STEP_P;

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    period_d     = PULSE_MAX;
    pulse_d      = pulse_q;
    tcnt_d       = tcnt_q;
    once_d       = once_q;
    lock_d       = lock_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    breath_end_c = 1'b0;
`ifdef BREATH_HOLD_EN
    hcnt_d       = hcnt_q;
`endif

    // A finished one-shot stays parked until en is dropped
    if (!en) begin
      lock_d = 1'b0;
    end

    if (state_q == ST_IDLE) begin
      pulse_d = PULSE_MIN;
      tcnt_d  = '0;
      busy_d  = 1'b0;
`ifdef BREATH_HOLD_EN
      hcnt_d  = '0;
`endif
      if (en && !lock_q) begin
        state_d = ST_RISE;
        once_d  = once;
        busy_d  = 1'b1;
      end
    end else if (!en) begin
      state_d = ST_IDLE;
      pulse_d = PULSE_MIN;
      tcnt_d  = '0;
      busy_d  = 1'b0;
`ifdef BREATH_HOLD_EN
      hcnt_d  = '0;
`endif
    end else begin
      tcnt_d = tick_c ? '0 : tcnt_q + TW'(1);
      if (tick_c) begin
        unique case (state_q)
          ST_RISE: begin
            if (pulse_up_c >= PERIOD_A) begin
              pulse_d = PULSE_MAX;
`ifdef BREATH_HOLD_EN
              state_d = ST_HOLD_HI;
`else
              state_d = ST_FALL;
`endif
            end else begin
              pulse_d = PW'(pulse_up_c);
            end
          end
          ST_FALL: begin
            if ({1'b0, pulse_q} <= STEP_A + AW'(1)) begin
              pulse_d = PULSE_MIN;
`ifdef BREATH_HOLD_EN
              state_d = ST_HOLD_LO;
`else
              breath_end_c = 1'b1;
`endif
            end else begin
              pulse_d = pulse_dn_c;
            end
          end
`ifdef BREATH_HOLD_EN
          ST_HOLD_HI: begin
            if (hcnt_q == HOLD_LAST) begin
              hcnt_d  = '0;
              state_d = ST_FALL;
            end else begin
              hcnt_d = hcnt_q + HW'(1);
            end
          end
          ST_HOLD_LO: begin
            if (hcnt_q == HOLD_LAST) begin
              hcnt_d       = '0;
              breath_end_c = 1'b1;
            end else begin
              hcnt_d = hcnt_q + HW'(1);
            end
          end
`endif
          default: begin
            state_d = ST_IDLE;
            pulse_d = PULSE_MIN;
            busy_d  = 1'b0;
          end
        endcase
      end

      // End of a full breath: strobe, then loop or park
      if (breath_end_c) begin
        done_d = 1'b1;
        if (once_q) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          lock_d  = 1'b1;
        end else begin
          state_d = ST_RISE;
        end
      end
    end
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      period_q <= PULSE_MAX;
      pulse_q  <= PULSE_MIN;
      tcnt_q   <= '0;
      once_q   <= 1'b0;
      lock_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef BREATH_HOLD_EN
      hcnt_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      pulse_q  <= pulse_d;
      tcnt_q   <= tcnt_d;
      once_q   <= once_d;
      lock_q   <= lock_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef BREATH_HOLD_EN
      hcnt_q   <= hcnt_d;
`endif
    end
  end

  assign period     = period_q;
  assign pulse      = pulse_q;
  assign busy       = busy_q;
  assign cycle_done = done_q;

endmodule

// File: tb/tb_breath_sequencer.sv
// Directed bench for breath_sequencer: DUT a uses STEP=3, DUT b uses STEP=9 (clamp case).
module tb_breath_sequencer;

  logic        sclk;
  logic        rst;
  logic        en;
  logic        once;
  logic [25:0] period_a, pulse_a, period_b, pulse_b;
  logic        busy_a, cd_a, busy_b, cd_b;

  int n_vec = 0;
  int n_bad = 0;
  int edge_n;

  breath_sequencer #(.PERIOD(10), .UPDATE_CLKS(4), .STEP(3), .HOLD_UPDATES(2)) u_a (
    .sclk(sclk), .rst(rst), .en(en), .once(once),
    .period(period_a), .pulse(pulse_a), .busy(busy_a), .cycle_done(cd_a)
  );

  breath_sequencer #(.PERIOD(10), .UPDATE_CLKS(4), .STEP(9), .HOLD_UPDATES(2)) u_b (
    .sclk(sclk), .rst(rst), .en(en), .once(once),
    .period(period_b), .pulse(pulse_b), .busy(busy_b), .cycle_done(cd_b)
  );

  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  typedef struct {
    int          n;
    logic        en;
    logic        once;
    logic [25:0] pa;
    logic        ca;
    logic [25:0] pb;
    logic        cb;
  } vec_t;

`ifdef BREATH_HOLD_EN
  localparam int ASYNC_N = 89;
  localparam int ABORT_N = 28;
  localparam int DONE_A  = 40;
  localparam int DONE_B  = 24;
  localparam int PA_PRE  = 10;
  localparam int PB_PRE  = 1;
`else
  localparam int ASYNC_N = 81;
  localparam int ABORT_N = 20;
  localparam int DONE_A  = 24;
  localparam int DONE_B  = 8;
  localparam int PA_PRE  = 4;
  localparam int PB_PRE  = 10;
`endif

  vec_t tbl[17];

  function automatic vec_t mk(input int n, input int pa, input int ca, input int pb, input int cb);
    vec_t v;
    v.n    = n;
    v.en   = 1'b1;
    v.once = 1'b0;
    v.pa   = 26'(pa);
    v.ca   = 1'(ca);
    v.pb   = 26'(pb);
    v.cb   = 1'(cb);
    return v;
  endfunction

  task automatic check(input string name, input int pa, input int ca, input int ba,
                       input int pb, input int cb, input int bb);
    logic bad;
    bad = 1'b0;
    n_vec++;
    if (pulse_a !== 26'(pa)) begin
      $display("FAIL %s: pulse_a=%0d expected %0d", name, pulse_a, pa); bad = 1'b1;
    end
    if (cd_a !== 1'(ca)) begin
      $display("FAIL %s: cycle_done_a=%0b expected %0d", name, cd_a, ca); bad = 1'b1;
    end
    if (busy_a !== 1'(ba)) begin
      $display("FAIL %s: busy_a=%0b expected %0d", name, busy_a, ba); bad = 1'b1;
    end
    if (pulse_b !== 26'(pb)) begin
      $display("FAIL %s: pulse_b=%0d expected %0d", name, pulse_b, pb); bad = 1'b1;
    end
    if (cd_b !== 1'(cb)) begin
      $display("FAIL %s: cycle_done_b=%0b expected %0d", name, cd_b, cb); bad = 1'b1;
    end
    if (busy_b !== 1'(bb)) begin
      $display("FAIL %s: busy_b=%0b expected %0d", name, busy_b, bb); bad = 1'b1;
    end
    if (period_a !== 26'd10 || period_b !== 26'd10) begin
      $display("FAIL %s: period_a=%0d period_b=%0d expected 10", name, period_a, period_b);
      bad = 1'b1;
    end
    if (bad) n_bad++;
  endtask

  // Advance to just after edge n (edge 0 is the first edge after the phase starts)
  task automatic run_to(input int n);
    if (edge_n < n) begin
      while (edge_n < n) begin
        @(posedge sclk);
        edge_n++;
      end
      #1;
    end
  endtask

  initial begin
`ifdef BREATH_HOLD_EN
    tbl[0]  = mk(0,  1, 0, 1, 0);
    tbl[1]  = mk(3,  1, 0, 1, 0);
    tbl[2]  = mk(4,  4, 0, 10, 0);
    tbl[3]  = mk(8,  7, 0, 10, 0);
    tbl[4]  = mk(12, 10, 0, 10, 0);
    tbl[5]  = mk(16, 10, 0, 1, 0);
    tbl[6]  = mk(20, 10, 0, 1, 0);
    tbl[7]  = mk(23, 10, 0, 1, 0);
    tbl[8]  = mk(24, 7, 0, 1, 1);
    tbl[9]  = mk(25, 7, 0, 1, 0);
    tbl[10] = mk(28, 4, 0, 10, 0);
    tbl[11] = mk(32, 1, 0, 10, 0);
    tbl[12] = mk(39, 1, 0, 10, 0);
    tbl[13] = mk(40, 1, 1, 1, 0);
    tbl[14] = mk(41, 1, 0, 1, 0);
    tbl[15] = mk(48, 7, 0, 1, 1);
    tbl[16] = mk(80, 1, 1, 10, 0);
`else
    tbl[0]  = mk(0,  1, 0, 1, 0);
    tbl[1]  = mk(3,  1, 0, 1, 0);
    tbl[2]  = mk(4,  4, 0, 10, 0);
    tbl[3]  = mk(8,  7, 0, 1, 1);
    tbl[4]  = mk(12, 10, 0, 10, 0);
    tbl[5]  = mk(16, 7, 0, 1, 1);
    tbl[6]  = mk(20, 4, 0, 10, 0);
    tbl[7]  = mk(23, 4, 0, 10, 0);
    tbl[8]  = mk(24, 1, 1, 1, 1);
    tbl[9]  = mk(25, 1, 0, 1, 0);
    tbl[10] = mk(28, 4, 0, 10, 0);
    tbl[11] = mk(32, 7, 0, 1, 1);
    tbl[12] = mk(39, 10, 0, 10, 0);
    tbl[13] = mk(40, 7, 0, 1, 1);
    tbl[14] = mk(41, 7, 0, 1, 0);
    tbl[15] = mk(48, 1, 1, 1, 1);
    tbl[16] = mk(80, 7, 0, 1, 1);
`endif

    rst  = 1'b1;
    en   = 1'b0;
    once = 1'b0;
    edge_n = -1;
    repeat (2) @(posedge sclk);
    #1;
    check("reset", 1, 0, 0, 1, 0, 0);
    rst = 1'b0;
    repeat (2) @(posedge sclk);
    #1;
    check("idle_en_low", 1, 0, 0, 1, 0, 0);

    // Looping breath, table driven
    edge_n = -1;
    for (int i = 0; i < 17; i++) begin
      en   = tbl[i].en;
      once = tbl[i].once;
      run_to(tbl[i].n);
      check($sformatf("loop_n%0d", tbl[i].n), int'(tbl[i].pa), int'(tbl[i].ca), 1,
            int'(tbl[i].pb), int'(tbl[i].cb), 1);
    end

    // Asynchronous reset in the middle of RISE
    run_to(ASYNC_N);
    check("pre_async_rst", 7, 0, 1, 1, 0, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst", 1, 0, 0, 1, 0, 0);
    @(posedge sclk);
    #1;
    en  = 1'b0;
    rst = 1'b0;
    @(posedge sclk);
    #1;

    // Abort on a tick edge while FALL holds pulse=7
    en = 1'b1;
    edge_n = -1;
    run_to(ABORT_N - 1);
    check("pre_abort", 7, 0, 1, 1, 0, 1);
    en = 1'b0;
    run_to(ABORT_N);
    check("abort", 1, 0, 0, 1, 0, 0);
    en = 1'b1;
    run_to(ABORT_N + 1);
    check("restart", 1, 0, 1, 1, 0, 1);
    run_to(ABORT_N + 5);
    check("restart_step", 4, 0, 1, 10, 0, 1);
    en = 1'b0;
    run_to(ABORT_N + 6);
    check("stop", 1, 0, 0, 1, 0, 0);

    // One-shot: single breath, then parked while en stays high
    en   = 1'b1;
    once = 1'b1;
    edge_n = -1;
    run_to(0);
    check("once_start", 1, 0, 1, 1, 0, 1);
    run_to(DONE_B - 1);
    check("once_b_pre", PA_PRE, 0, 1, PB_PRE, 0, 1);
    run_to(DONE_B);
    check("once_b_done", 7, 0, 1, 1, 1, 0);
    run_to(DONE_B + 1);
    check("once_b_after", 7, 0, 1, 1, 0, 0);
    run_to(DONE_A);
    check("once_a_done", 1, 1, 0, 1, 0, 0);
    run_to(DONE_A + 1);
    check("once_a_after", 1, 0, 0, 1, 0, 0);
    run_to(DONE_A + 20);
    check("once_parked", 1, 0, 0, 1, 0, 0);
    en = 1'b0;
    run_to(DONE_A + 21);
    check("once_en_low", 1, 0, 0, 1, 0, 0);
    en   = 1'b1;
    once = 1'b0;
    run_to(DONE_A + 22);
    check("once_rearm", 1, 0, 1, 1, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
